mux_nto1_arb: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every channel and a one-word output holding register. Channel selection is either fixed, driven by an external select, or round-robin arbitration among the valid channels. It sits between datapath producers and a single consumer, for example a shared writeback or memory-request port in the MIPS pipeline. It supersedes the plain combinational 2:1 selectors wherever a stall or backpressure is possible.

---
 rtl/mux_nto1_arb_if.sv | 26 ++
 rtl/mux_nto1_arb.sv | 88 ++++++++
 tb/tb_mux_nto1_arb.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mux_nto1_arb_if.sv
// rtl/mux_nto1_arb_if.sv - handshake and data bundle between N producers, the mux and one consumer
interface mux_nto1_arb_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
);
  logic                 Mode;
  logic [SELW-1:0]      Sel;
  logic [N*WIDTH-1:0]   InData;
  logic [N-1:0]         InValid;
  logic [N-1:0]         InReady;
  logic [WIDTH-1:0]     Out;
  logic [SELW-1:0]      OutSel;
  logic                 OutValid;
  logic                 OutReady;

  modport slave (
    input  Mode, Sel, InData, InValid, OutReady,
    output InReady, Out, OutSel, OutValid
  );

  modport master (
    output Mode, Sel, InData, InValid, OutReady,
    input  InReady, Out, OutSel, OutValid
  );
endinterface

// File: rtl/mux_nto1_arb.sv
// rtl/mux_nto1_arb.sv - N-to-1 registered mux with fixed or round-robin channel grant
module mux_nto1_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic          Clk,
  input  logic          Rst,
  mux_nto1_arb_if.slave bus
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic             space;
  logic             xfer;

  // Pick at most one channel: external select in mode 0, rotating scan after ptr_q in mode 1
  always_comb begin
    logic [SELW-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    if (!bus.Mode) begin
      if (int'(bus.Sel) < N) begin
        if (bus.InValid[bus.Sel]) begin
          grant_vld = 1'b1;
          grant_idx = bus.Sel;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = SELW'((int'(ptr_q) + k) % N);
        if (!grant_vld && bus.InValid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
    end
  end

  // Room in the holding register this cycle; ready is withheld while in reset
  assign space       = ~out_valid_q | bus.OutReady;
  assign xfer        = Rst & grant_vld & space;
  assign bus.InReady = xfer ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

  // Next-state for the holding register and the round-robin pointer
  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_d       = bus.InData[grant_idx*WIDTH +: WIDTH];
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      if (bus.Mode) begin
        ptr_d = grant_idx;
      end
    end else if (bus.OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset leaves the pointer on the last channel so channel 0 wins first
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      out_q       <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(N - 1);
    end else begin
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.Out      = out_q;
  assign bus.OutSel   = out_sel_q;
  assign bus.OutValid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// tb/tb_mux_nto1_arb.sv - self-checking bench for mux_nto1_arb
module tb_mux_nto1_arb;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  mux_nto1_arb_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();

  mux_nto1_arb #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] chdata [N];

  // reference model state
  bit               m_valid;
  logic [WIDTH-1:0] m_out;
  int               m_sel;
  int               m_ptr;
  int               m_g;
  logic [N-1:0]     m_ready;
  bit               c_rst;
  bit               c_mode;
  bit               c_ordy;

  typedef struct {
    bit          rst;
    bit          mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    bit          ordy;
    logic [3:0]  e_ready;
    bit          e_ov;
    logic [1:0]  e_sel;
    logic [31:0] e_out;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Winner is the valid channel at the smallest rotational distance past the pointer
  function automatic int ref_grant(bit mode, int sel, logic [N-1:0] valid, int ptr);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    if (!mode) begin
      if (sel < N && valid[sel]) return sel;
      return -1;
    end
    for (int i = 0; i < N; i++) begin
      if (valid[i]) begin
        d = (i - ptr - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic drive(input bit rst, input bit mode, input logic [1:0] sel,
                       input logic [N-1:0] valid, input bit ordy);
    Rst          = rst;
    bus.Mode     = mode;
    bus.Sel      = sel;
    bus.InValid  = valid;
    bus.OutReady = ordy;
    for (int i = 0; i < N; i++) bus.InData[i*WIDTH +: WIDTH] = chdata[i];
    c_rst   = rst;
    c_mode  = mode;
    c_ordy  = ordy;
    m_g     = ref_grant(mode, int'(sel), valid, m_ptr);
    m_ready = '0;
    if (rst && m_g >= 0 && (!m_valid || ordy)) m_ready[m_g] = 1'b1;
  endtask

  task automatic clock_edge();
    @(posedge Clk);
    if (!c_rst) begin
      m_valid = 1'b0;
      m_out   = '0;
      m_sel   = 0;
      m_ptr   = N - 1;
    end else if (m_ready != '0) begin
      m_out   = chdata[m_g];
      m_sel   = m_g;
      m_valid = 1'b1;
      if (c_mode) m_ptr = m_g;
    end else if (c_ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic cyc(input string tag, input bit rst, input bit mode, input logic [1:0] sel,
                     input logic [3:0] valid, input bit ordy, input logic [3:0] e_ready,
                     input bit e_ov, input logic [1:0] e_sel, input logic [31:0] e_out);
    drive(rst, mode, sel, valid, ordy);
    #1;
    chk({tag, " ready"}, 64'(bus.InReady), 64'(e_ready));
    clock_edge();
    chk({tag, " outvalid"}, 64'(bus.OutValid), 64'(e_ov));
    chk({tag, " outsel"}, 64'(bus.OutSel), 64'(e_sel));
    chk({tag, " out"}, 64'(bus.Out), 64'(e_out));
  endtask

  initial begin
    chdata[0] = 32'h0000_0A00;
    chdata[1] = 32'h0000_0B11;
    chdata[2] = 32'hDEAD_BEEF;
    chdata[3] = 32'h0000_0D33;
    m_valid = 1'b0;
    m_out   = '0;
    m_sel   = 0;
    m_ptr   = N - 1;

    tbl[0]  = '{0, 1, 2'd0, 4'hF,    1, 4'b0000, 0, 2'd0, 32'h0};
    tbl[1]  = '{0, 1, 2'd0, 4'hF,    1, 4'b0000, 0, 2'd0, 32'h0};
    tbl[2]  = '{1, 1, 2'd0, 4'hF,    1, 4'b0001, 1, 2'd0, 32'h0000_0A00};
    tbl[3]  = '{1, 0, 2'd2, 4'hF,    1, 4'b0100, 1, 2'd2, 32'hDEAD_BEEF};
    tbl[4]  = '{1, 0, 2'd3, 4'b0111, 1, 4'b0000, 0, 2'd2, 32'hDEAD_BEEF};
    tbl[5]  = '{1, 1, 2'd0, 4'hF,    1, 4'b0010, 1, 2'd1, 32'h0000_0B11};
    tbl[6]  = '{1, 1, 2'd0, 4'hF,    1, 4'b0100, 1, 2'd2, 32'hDEAD_BEEF};
    tbl[7]  = '{1, 1, 2'd0, 4'hF,    1, 4'b1000, 1, 2'd3, 32'h0000_0D33};
    tbl[8]  = '{1, 1, 2'd0, 4'hF,    1, 4'b0001, 1, 2'd0, 32'h0000_0A00};
    tbl[9]  = '{1, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1, 32'h0000_0B11};
    tbl[10] = '{1, 1, 2'd0, 4'b1010, 1, 4'b1000, 1, 2'd3, 32'h0000_0D33};
    tbl[11] = '{1, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1, 32'h0000_0B11};
    tbl[12] = '{1, 1, 2'd0, 4'b1010, 1, 4'b1000, 1, 2'd3, 32'h0000_0D33};
    tbl[13] = '{1, 1, 2'd0, 4'hF,    0, 4'b0000, 1, 2'd3, 32'h0000_0D33};
    tbl[14] = '{1, 1, 2'd0, 4'hF,    0, 4'b0000, 1, 2'd3, 32'h0000_0D33};
    tbl[15] = '{1, 1, 2'd0, 4'hF,    0, 4'b0000, 1, 2'd3, 32'h0000_0D33};
    tbl[16] = '{1, 1, 2'd0, 4'hF,    1, 4'b0001, 1, 2'd0, 32'h0000_0A00};

    drive(0, 1, 2'd0, 4'hF, 1);
    clock_edge();

    for (int v = 0; v < 17; v++) begin
      cyc($sformatf("vec%0d", v), tbl[v].rst, tbl[v].mode, tbl[v].sel, tbl[v].valid,
          tbl[v].ordy, tbl[v].e_ready, tbl[v].e_ov, tbl[v].e_sel, tbl[v].e_out);
    end

    // mode switch while stalled: held word untouched, pointer kept at 1
    cyc("msw_load1", 1, 1, 2'd0, 4'b0010, 1, 4'b0010, 1, 2'd1, 32'h0000_0B11);
    cyc("msw_stall0", 1, 0, 2'd0, 4'b0011, 0, 4'b0000, 1, 2'd1, 32'h0000_0B11);
    cyc("msw_stall1", 1, 0, 2'd0, 4'b0011, 0, 4'b0000, 1, 2'd1, 32'h0000_0B11);
    cyc("msw_fixed0", 1, 0, 2'd0, 4'b0011, 1, 4'b0001, 1, 2'd0, 32'h0000_0A00);
    cyc("msw_rr2", 1, 1, 2'd0, 4'hF, 1, 4'b0100, 1, 2'd2, 32'hDEAD_BEEF);

    // reset while a word is stalled in the holding register
    cyc("rst_stall", 1, 1, 2'd0, 4'h0, 0, 4'b0000, 1, 2'd2, 32'hDEAD_BEEF);
    cyc("rst_apply", 0, 1, 2'd0, 4'hF, 0, 4'b0000, 0, 2'd0, 32'h0);
    cyc("rst_first", 1, 1, 2'd0, 4'hF, 1, 4'b0001, 1, 2'd0, 32'h0000_0A00);

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) chdata[i] = $urandom;
      drive(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      #1;
      chk("rand ready", 64'(bus.InReady), 64'(m_ready));
      clock_edge();
      chk("rand outvalid", 64'(bus.OutValid), 64'(m_valid));
      chk("rand outsel", 64'(bus.OutSel), 64'(m_sel));
      chk("rand out", 64'(bus.Out), 64'(m_out));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
